pc_jump_unit: RTL and testbench
===============================

Name: pc_jump_unit

Overview:
- Parametrised successor to the CPU jump controller: evaluates the 3-bit jump field against ALU flags and also owns the program counter register.
- Sits between decode/ALU and instruction fetch.
- Adds a stall enable, a configurable reset vector and address wrap.
- Adds a registered one-cycle fetch flush after taken jumps, and a saturating taken-jump counter.

Parameters:
- ADDR_W, 15, program counter / jump target width in bits.
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).
- JCNT_W, 16, width of the taken-jump counter.
- STK_DEPTH, 8, return-stack entries; used only with the optional feature, must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; 0 = stall, all state holds.
- c_valid  input  1  current instruction is a C-instruction; jump field is ignored when 0.
- cmd_j  input  3  jump field {j1,j2,j3}: j1 = less-than, j2 = equal, j3 = greater-than.
- alu_zr  input  1  ALU result is zero.
- alu_ng  input  1  ALU result is negative.
- target  input  ADDR_W  jump target (A register).
- call  input  1  optional feature only: taken jump is a call.
- ret  input  1  optional feature only: return.
- pc  output  ADDR_W  current program counter (registered).
- pc_load  output  1  combinational: PC loads a new value this cycle.
- pc_inc  output  1  combinational: PC increments this cycle.
- flush  output  1  registered: discard the fetched instruction.
- jump_cnt  output  JCNT_W  taken-jump count, saturating.
- stk_err  output  1  optional feature only: sticky stack overflow/underflow flag; tied to 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_VEC.
  - flush = 0, jump_cnt = 0, stk_err = 0, stack pointer = 0.
  - Reset takes effect immediately, including mid-stall.
- Condition decode:
  - take = c_valid & ((j1 & ng & ~zr) | (j2 & zr) | (j3 & ~zr & ~ng)).
  - 000 never jumps; 111 always jumps.
  - The inconsistent flag pair zr=1, ng=1 is treated as zero: JEQ, JGE and JLE take; JLT does not.
- Outputs when en=1: pc_load = take, pc_inc = ~take. Exactly one is high.
- Outputs when en=0: pc_load = pc_inc = 0.
- Next PC on a clock edge with en=1:
  - take=1: pc ← target.
  - otherwise: pc ← pc+1, modulo 2^ADDR_W, so all-ones wraps to 0.
- Latency: the new pc is visible one cycle after the deciding edge.
- flush:
  - Updates only when en=1: flush ← take (pc_load); one-cycle pulse per taken jump.
  - With back-to-back taken jumps, flush stays high.
  - When en=0, flush holds its value.
- jump_cnt:
  - Increments on each edge with en=1 and pc_load=1.
  - Saturates at 2^JCNT_W−1 with no wrap.
- c_valid=0 (A-instruction): increment only, regardless of cmd_j and flags.

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- When defined, a return stack of STK_DEPTH × ADDR_W is instantiated with a pointer sp (0 = empty).
  - Call (en & take & call): push pc+1 (wrapped), pc ← target.
  - Call when full: the push is dropped, the jump still happens, stk_err ← 1.
  - Return (en & ret & c_valid): pc ← top, pop; pc_load=1, pc_inc=0, flush ← 1; jump_cnt increments.
  - ret has priority over take and call. When ret=1, call is ignored (no push).
  - Return when empty: behaves as an increment (pc_inc=1), no flush, stk_err ← 1.
  - stk_err is sticky until reset.
- When not defined:
  - No stack storage.
  - call and ret inputs are ignored.
  - stk_err is tied to 0.

Test Plan:
1. Reset with RESET_VEC=0x0100, then en=1, c_valid=0 for 3 cycles -> pc = 0x100, 0x101, 0x102, 0x103; flush=0; jump_cnt=0.
2. Decode sweep: all 8 values of cmd_j × flag pairs (zr,ng) ∈ {(0,0),(1,0),(0,1)}, with target=0x2A -> pc_load matches the take equation; pc=0x2A after taken cases; flush high exactly one cycle after each taken case.
3. pc=0x7FFF (ADDR_W=15), no jump -> pc=0x0000. JMP(111) with target=0x1234 and en=0 for 2 cycles -> pc, flush and jump_cnt hold; pc_load=0 and pc_inc=0.
4. JCNT_W=4: 17 consecutive JMPs -> jump_cnt = 15 (saturated); flush stays 1 throughout the run.
5. Assert rst_n low mid-run during a taken JMP -> pc=RESET_VEC, flush=0 and jump_cnt=0 immediately, without waiting for a clock edge.
6. PC_CALL_STACK_EN, STK_DEPTH=2:
   - call at pc=0x10 to 0x40, then call at 0x40 to 0x80, then a third call -> stk_err=1 and pc=target.
   - ret, ret -> pc=0x41, then pc=0x11.
   - A further ret -> pc increments and stk_err stays 1.

Source files
------------

// File: rtl/pc_jump_unit.sv
// Program counter with jump-condition decode, fetch flush and a saturating taken-jump counter.
// Optional return stack for call/ret is compiled in with `define PC_CALL_STACK_EN.
module pc_jump_unit #(
    parameter int                  ADDR_W    = 15,
    parameter logic [ADDR_W-1:0]   RESET_VEC = '0,
    parameter int                  JCNT_W    = 16,
    parameter int                  STK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              c_valid,
    input  logic [2:0]        cmd_j,
    input  logic              alu_zr,
    input  logic              alu_ng,
    input  logic [ADDR_W-1:0] target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_load,
    output logic              pc_inc,
    output logic              flush,
    output logic [JCNT_W-1:0] jump_cnt,
    output logic              stk_err
);

    if (STK_DEPTH < 2) begin : g_depth_chk
        $error("pc_jump_unit: STK_DEPTH must be at least 2");
    end

    logic [ADDR_W-1:0] r_pc;
    logic              r_flush;
    logic [JCNT_W-1:0] r_jcnt;

    logic              w_take;
    logic              w_load;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_next;

    // zr=1,ng=1 is treated as zero: the less-than term requires ~zr
    assign w_take = c_valid & ((cmd_j[2] & alu_ng & ~alu_zr)
                             | (cmd_j[1] & alu_zr)
                             | (cmd_j[0] & ~alu_zr & ~alu_ng));

    assign w_pc_seq = r_pc + 1'b1;

`ifdef PC_CALL_STACK_EN
    localparam int SP_W  = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = $clog2(STK_DEPTH);

    logic [ADDR_W-1:0] r_stk [STK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_stk_err;

    logic w_ret;
    logic w_ret_ok;
    logic w_call;
    logic w_full;

    // ret wins over take/call; an empty-stack return degrades to an increment
    assign w_ret    = c_valid & ret;
    assign w_ret_ok = w_ret & (r_sp != '0);
    assign w_full   = (r_sp == SP_W'(STK_DEPTH));
    assign w_call   = w_take & call & ~w_ret;
    assign w_load   = w_ret ? w_ret_ok : w_take;
    assign w_target = w_ret_ok ? r_stk[IDX_W'(r_sp - 1'b1)] : target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp      <= '0;
            r_stk_err <= 1'b0;
        end else if (en) begin
            if (w_ret_ok) begin
                r_sp <= r_sp - 1'b1;
            end else if (w_call && !w_full) begin
                r_sp <= r_sp + 1'b1;
            end
            if ((w_ret && !w_ret_ok) || (w_call && w_full)) begin
                r_stk_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && w_call && !w_full) begin
            r_stk[IDX_W'(r_sp)] <= w_pc_seq;
        end
    end

    assign stk_err = r_stk_err;
`else
    assign w_load   = w_take;
    assign w_target = target;
    // call/ret have no function in this build; folded into a constant zero
    assign stk_err  = &{1'b0, call, ret};
`endif

    assign w_pc_next = w_load ? w_target : w_pc_seq;

    assign pc_load = en & w_load;
    assign pc_inc  = en & ~w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_VEC;
            r_flush <= 1'b0;
            r_jcnt  <= '0;
        end else if (en) begin
            r_pc    <= w_pc_next;
            r_flush <= w_load;
            if (w_load && (r_jcnt != '1)) begin
                r_jcnt <= r_jcnt + 1'b1;
            end
        end
    end

    assign pc       = r_pc;
    assign flush    = r_flush;
    assign jump_cnt = r_jcnt;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed self-checking bench for pc_jump_unit (RESET_VEC=0x100, JCNT_W=4, STK_DEPTH=2).
module tb_pc_jump_unit;

    localparam int              ADDR_W    = 15;
    localparam logic [14:0]     RESET_VEC = 15'h0100;
    localparam int              JCNT_W    = 4;
    localparam int              STK_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              c_valid;
    logic [2:0]        cmd_j;
    logic              alu_zr;
    logic              alu_ng;
    logic [ADDR_W-1:0] target;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;
    logic              flush;
    logic [JCNT_W-1:0] jump_cnt;
    logic              stk_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] exp_pc;
    logic              exp_flush;
    logic [JCNT_W-1:0] exp_cnt;

    pc_jump_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(RESET_VEC),
        .JCNT_W   (JCNT_W),
        .STK_DEPTH(STK_DEPTH)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .c_valid (c_valid),
        .cmd_j   (cmd_j),
        .alu_zr  (alu_zr),
        .alu_ng  (alu_ng),
        .target  (target),
        .call    (call),
        .ret     (ret),
        .pc      (pc),
        .pc_load (pc_load),
        .pc_inc  (pc_inc),
        .flush   (flush),
        .jump_cnt(jump_cnt),
        .stk_err (stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Advance one edge and update the reference state for an enabled cycle.
    task automatic clk_edge(input logic take);
        logic [ADDR_W-1:0] tgt;
        tgt = target;
        @(posedge clk);
        #1;
        if (en) begin
            exp_pc    = take ? tgt : exp_pc + 15'd1;
            exp_flush = take;
            if (take && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"},    32'(pc),       32'(exp_pc));
        check({tag, ".flush"}, 32'(flush),    32'(exp_flush));
        check({tag, ".jcnt"},  32'(jump_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [2:0] jv;
        logic       tk;
        rst_n = 1'b0; en = 1'b0; c_valid = 1'b0; cmd_j = 3'b000;
        alu_zr = 1'b0; alu_ng = 1'b0; target = '0; call = 1'b0; ret = 1'b0;
        exp_pc = RESET_VEC; exp_flush = 1'b0; exp_cnt = '0;

        // reset state
        #7;
        check_state("rst");
        check("rst.stk_err", 32'(stk_err), 0);
        check("rst.pc_load", 32'(pc_load), 0);
        check("rst.pc_inc",  32'(pc_inc),  0);

        // sequential fetch from reset vector
        #5;
        rst_n = 1'b1; en = 1'b1;
        #1;
        check("seq.pc_inc", 32'(pc_inc), 1);
        for (int i = 0; i < 3; i++) begin
            clk_edge(1'b0);
            check_state("seq");
        end
        check("seq.pc_103", 32'(pc), 32'h103);

        // decode sweep: flags (0,0)=positive, (1,0)=zero, (0,1)=negative
        target = 15'h002A;
        c_valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            for (int f = 0; f < 3; f++) begin
                jv     = 3'(j);
                cmd_j  = jv;
                alu_zr = (f == 1);
                alu_ng = (f == 2);
                tk     = (f == 0) ? jv[0] : (f == 1) ? jv[1] : jv[2];
                #1;
                check($sformatf("dec%0d_%0d.pc_load", j, f), 32'(pc_load), 32'(tk));
                check($sformatf("dec%0d_%0d.pc_inc", j, f),  32'(pc_inc),  32'(!tk));
                clk_edge(tk);
                check_state($sformatf("dec%0d_%0d", j, f));
            end
        end
        check("dec.jcnt_12", 32'(jump_cnt), 12);

        // inconsistent flags zr=1, ng=1 behave as zero
        alu_zr = 1'b1; alu_ng = 1'b1;
        cmd_j = 3'b100; #1; check("zn.JLT", 32'(pc_load), 0);
        cmd_j = 3'b010; #1; check("zn.JEQ", 32'(pc_load), 1);
        cmd_j = 3'b011; #1; check("zn.JGE", 32'(pc_load), 1);
        cmd_j = 3'b110; #1; check("zn.JLE", 32'(pc_load), 1);

        // A-instruction ignores the jump field
        c_valid = 1'b0; cmd_j = 3'b111;
        #1;
        check("ainst.pc_load", 32'(pc_load), 0);
        check("ainst.pc_inc",  32'(pc_inc),  1);

        // wrap at all-ones
        c_valid = 1'b1; target = 15'h7FFF;
        clk_edge(1'b1);
        check_state("wrap_pre");
        c_valid = 1'b0;
        clk_edge(1'b0);
        check_state("wrap");
        check("wrap.pc_0", 32'(pc), 0);

        // stall with a pending JMP
        c_valid = 1'b1; cmd_j = 3'b111; target = 15'h1234; en = 1'b0;
        #1;
        check("stall.pc_load", 32'(pc_load), 0);
        check("stall.pc_inc",  32'(pc_inc),  0);
        for (int i = 0; i < 2; i++) begin
            clk_edge(1'b1);
            check_state("stall");
        end

        // flush holds high across a stall
        en = 1'b1; target = 15'h0055;
        clk_edge(1'b1);
        check_state("jmp55");
        en = 1'b0; c_valid = 1'b0;
        clk_edge(1'b0);
        check_state("stall_flush");
        check("stall_flush.hi", 32'(flush), 1);

        // async reset mid-cycle during a taken JMP
        en = 1'b1; c_valid = 1'b1; target = 15'h0321;
        clk_edge(1'b1);
        check_state("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_pc = RESET_VEC; exp_flush = 1'b0; exp_cnt = '0;
        check_state("async_rst");
        #2;
        rst_n = 1'b1;

        // saturation over 17 back-to-back JMPs
        for (int i = 0; i < 17; i++) begin
            target = 15'(32'h200 + i);
            clk_edge(1'b1);
            check_state($sformatf("sat%0d", i));
        end
        check("sat.jcnt_15", 32'(jump_cnt), 15);

`ifdef PC_CALL_STACK_EN
        target = 15'h0010;
        clk_edge(1'b1);
        check("stk.pc_10", 32'(pc), 32'h10);
        call = 1'b1; target = 15'h0040;
        clk_edge(1'b1);
        check("stk.call1", 32'(pc), 32'h40);
        target = 15'h0080;
        clk_edge(1'b1);
        check("stk.call2", 32'(pc), 32'h80);
        check("stk.no_err", 32'(stk_err), 0);
        target = 15'h00C0;
        clk_edge(1'b1);
        check("stk.call3", 32'(pc), 32'hC0);
        check("stk.ovf", 32'(stk_err), 1);
        call = 1'b0; ret = 1'b1; cmd_j = 3'b000;
        #1;
        check("stk.ret_load", 32'(pc_load), 1);
        @(posedge clk); #1;
        check("stk.ret1", 32'(pc), 32'h41);
        check("stk.ret1_flush", 32'(flush), 1);
        @(posedge clk); #1;
        check("stk.ret2", 32'(pc), 32'h11);
        #1;
        check("stk.unf_inc", 32'(pc_inc), 1);
        @(posedge clk); #1;
        check("stk.unf_pc", 32'(pc), 32'h12);
        check("stk.unf_flush", 32'(flush), 0);
        check("stk.err_sticky", 32'(stk_err), 1);
        ret = 1'b0;
`else
        // call/ret have no effect without the stack
        ret = 1'b1; call = 1'b1; cmd_j = 3'b000;
        #1;
        check("nostk.ret_load", 32'(pc_load), 0);
        clk_edge(1'b0);
        check_state("nostk");
        check("nostk.stk_err", 32'(stk_err), 0);
        ret = 1'b0; call = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
